// File: rtl/watches_pkg.sv
// Shared types and limits for the watch time-setting logic.
package watches_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    COMMIT    = 2'd3
  } set_state_t;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;

  // Out-of-range values also wrap to 0, so a bad input can never leave the range.
  function automatic logic [4:0] next_hour(input logic [4:0] hour);
    return (hour >= HOUR_MAX) ? 5'd0 : hour + 5'd1;
  endfunction

  function automatic logic [5:0] next_min(input logic [5:0] min);
    return (min >= MIN_MAX) ? 6'd0 : min + 6'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, counting debouncer and rising-edge press detector for one button.
module btn_debounce #(
  parameter int DB_TACTS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DB_TACTS + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
    end
  end

  // Any return of the synced level to the debounced level restarts the count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_q2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DB_TACTS - 1)) begin
      cnt   <= '0;
      level <= sync_q2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      level_d <= 1'b0;
      press_o <= 1'b0;
    end else begin
      level_d <= level;
      press_o <= level & ~level_d;
    end
  end

endmodule

// File: rtl/watches_time_set.sv
// Two-button time setting: mode steps hour -> minute -> commit, inc bumps the field.
module watches_time_set
  import watches_pkg::*;
#(
  parameter int CLK_FREQ    = 50,
  parameter int SIM         = 0,
  parameter int DEBOUNCE_MS = 20,
  parameter int TIMEOUT_S   = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  output logic       user_time_val_o,
  output logic [4:0] user_hour_o,
  output logic [5:0] user_min_o,
  output logic       edit_o,
  output logic [1:0] field_o
);

  localparam int DB_TACTS = (SIM != 0) ? DEBOUNCE_MS : CLK_FREQ * 1000 * DEBOUNCE_MS;
  localparam int TO_TACTS = (SIM != 0) ? TIMEOUT_S * CLK_FREQ : TIMEOUT_S * CLK_FREQ * 1000000;
  localparam int TO_W     = $clog2(TO_TACTS);

  logic            mode_press;
  logic            inc_press;
  set_state_t      state;
  set_state_t      state_nxt;
  logic [4:0]      shadow_hour;
  logic [4:0]      shadow_hour_nxt;
  logic [5:0]      shadow_min;
  logic [5:0]      shadow_min_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic            timeout;
  logic [1:0]      field_nxt;

  btn_debounce #(.DB_TACTS(DB_TACTS)) u_mode (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_mode_i),
    .press_o (mode_press)
  );

  btn_debounce #(.DB_TACTS(DB_TACTS)) u_inc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_inc_i),
    .press_o (inc_press)
  );

  assign timeout = (to_cnt == TO_W'(TO_TACTS - 1));

  // Mode outranks inc, and any press outranks the timeout by restarting the count.
  always_comb begin
    state_nxt       = state;
    shadow_hour_nxt = shadow_hour;
    shadow_min_nxt  = shadow_min;
    to_cnt_nxt      = '0;
    case (state)
      IDLE: begin
        if (mode_press) begin
          state_nxt       = EDIT_HOUR;
          shadow_hour_nxt = (cur_hour_i > HOUR_MAX) ? 5'd0 : cur_hour_i;
          shadow_min_nxt  = (cur_min_i > MIN_MAX) ? 6'd0 : cur_min_i;
        end
      end
      EDIT_HOUR: begin
        if (mode_press) begin
          state_nxt = EDIT_MIN;
        end else if (inc_press) begin
          shadow_hour_nxt = next_hour(shadow_hour);
        end else if (timeout) begin
          state_nxt       = IDLE;
          shadow_hour_nxt = '0;
          shadow_min_nxt  = '0;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      EDIT_MIN: begin
        if (mode_press) begin
          state_nxt = COMMIT;
        end else if (inc_press) begin
          shadow_min_nxt = next_min(shadow_min);
        end else if (timeout) begin
          state_nxt       = IDLE;
          shadow_hour_nxt = '0;
          shadow_min_nxt  = '0;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    field_nxt = FIELD_NONE;
    case (state_nxt)
      EDIT_HOUR: field_nxt = FIELD_HOUR;
      EDIT_MIN:  field_nxt = FIELD_MIN;
      default:   field_nxt = FIELD_NONE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      shadow_hour     <= '0;
      shadow_min      <= '0;
      to_cnt          <= '0;
      user_time_val_o <= 1'b0;
      user_hour_o     <= '0;
      user_min_o      <= '0;
      edit_o          <= 1'b0;
      field_o         <= FIELD_NONE;
    end else begin
      state           <= state_nxt;
      shadow_hour     <= shadow_hour_nxt;
      shadow_min      <= shadow_min_nxt;
      to_cnt          <= to_cnt_nxt;
      user_time_val_o <= (state_nxt == COMMIT);
      if (state_nxt == COMMIT) begin
        user_hour_o <= shadow_hour_nxt;
        user_min_o  <= shadow_min_nxt;
      end
      edit_o  <= (state_nxt == EDIT_HOUR) || (state_nxt == EDIT_MIN);
      field_o <= field_nxt;
    end
  end

endmodule

// File: tb/tb_watches_time_set.sv
// Randomised scoreboard bench for watches_time_set against a simple time-setting model.
module tb_watches_time_set;

  localparam int DB = 4;
  localparam int TO = 100;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       btn_mode_i = 1'b0;
  logic       btn_inc_i = 1'b0;
  logic [4:0] cur_hour_i = '0;
  logic [5:0] cur_min_i = '0;
  logic       user_time_val_o;
  logic [4:0] user_hour_o;
  logic [5:0] user_min_o;
  logic       edit_o;
  logic [1:0] field_o;

  typedef struct {
    int hour;
    int min;
  } commit_t;

  commit_t exp_q[$];
  int      errors = 0;
  int      checks = 0;
  int      phase = 0;
  int      model_hour = 0;
  int      model_min = 0;
  int      last_hour = 0;
  int      last_min = 0;

  watches_time_set #(
    .CLK_FREQ    (50),
    .SIM         (1),
    .DEBOUNCE_MS (DB),
    .TIMEOUT_S   (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .btn_mode_i      (btn_mode_i),
    .btn_inc_i       (btn_inc_i),
    .cur_hour_i      (cur_hour_i),
    .cur_min_i       (cur_min_i),
    .user_time_val_o (user_time_val_o),
    .user_hour_o     (user_hour_o),
    .user_min_o      (user_min_o),
    .edit_o          (edit_o),
    .field_o         (field_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every strobe must match the oldest predicted commit.
  always @(negedge clk_i) begin
    commit_t e;
    if (user_time_val_o) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("commit_hour", int'(user_hour_o), e.hour);
        check_output("commit_min", int'(user_min_o), e.min);
      end
    end
  end

  task automatic drive(input bit mode, input bit inc, input bit level);
    if (mode) btn_mode_i = level;
    if (inc) btn_inc_i = level;
  endtask

  task automatic bounce_to(input bit mode, input bit inc, input bit level);
    int nb;
    nb = 2 * $urandom_range(0, 2);
    for (int i = 0; i < nb; i++) begin
      drive(mode, inc, (i % 2 == 0) ? level : ~level);
      repeat ($urandom_range(1, 2)) @(negedge clk_i);
    end
    drive(mode, inc, level);
    repeat (DB + 8) @(negedge clk_i);
  endtask

  task automatic predict(input bit mode, input bit inc);
    commit_t c;
    if (mode) begin
      case (phase)
        0: begin
          model_hour = int'(cur_hour_i);
          model_min  = int'(cur_min_i);
          phase      = 1;
        end
        1: phase = 2;
        default: begin
          c.hour = model_hour;
          c.min  = model_min;
          exp_q.push_back(c);
          last_hour = model_hour;
          last_min  = model_min;
          phase     = 0;
        end
      endcase
    end else if (inc) begin
      if (phase == 1) model_hour = (model_hour + 1) % 24;
      else if (phase == 2) model_min = (model_min + 1) % 60;
    end
  endtask

  task automatic check_field();
    check_output("field", int'(field_o), phase);
    check_output("edit", int'(edit_o), (phase != 0) ? 1 : 0);
  endtask

  // One complete press-and-release with random bounce on both edges.
  task automatic apply_stimulus(input bit mode, input bit inc);
    predict(mode, inc);
    bounce_to(mode, inc, 1'b1);
    bounce_to(mode, inc, 1'b0);
    check_field();
  endtask

  task automatic run_session(input int h, input int m, input int nh, input int nm);
    cur_hour_i = 5'(h);
    cur_min_i  = 6'(m);
    apply_stimulus(1, 0);
    repeat (nh) apply_stimulus(0, 1);
    apply_stimulus(1, 0);
    repeat (nm) apply_stimulus(0, 1);
    apply_stimulus(1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check_output("reset_val", int'(user_time_val_o), 0);
    check_output("reset_hour", int'(user_hour_o), 0);
    check_output("reset_min", int'(user_min_o), 0);
    check_output("reset_edit", int'(edit_o), 0);
    check_output("reset_field", int'(field_o), 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] full set 10:30 -> 13:32");
    run_session(10, 30, 3, 2);

    $display("[TB] wrap 23:59 -> 00:00");
    run_session(23, 59, 1, 1);

    $display("[TB] inc ignored in idle");
    cur_hour_i = 5'd3;
    cur_min_i  = 6'd7;
    apply_stimulus(0, 1);

    $display("[TB] bounce on inc");
    cur_hour_i = 5'd7;
    cur_min_i  = 6'd15;
    apply_stimulus(1, 0);
    predict(0, 1);
    for (int i = 0; i < 10; i++) begin
      btn_inc_i = (i % 2 == 0);
      repeat (2) @(negedge clk_i);
    end
    btn_inc_i = 1'b1;
    repeat (50) @(negedge clk_i);
    btn_inc_i = 1'b0;
    repeat (DB + 8) @(negedge clk_i);
    check_field();
    apply_stimulus(1, 0);
    apply_stimulus(1, 0);

    $display("[TB] simultaneous mode and inc");
    cur_hour_i = 5'd5;
    cur_min_i  = 6'd40;
    apply_stimulus(1, 0);
    apply_stimulus(1, 1);
    apply_stimulus(0, 1);
    apply_stimulus(1, 0);

    $display("[TB] edit timeout");
    cur_hour_i = 5'd12;
    cur_min_i  = 6'd0;
    apply_stimulus(1, 0);
    apply_stimulus(0, 1);
    repeat (TO + 20) @(negedge clk_i);
    phase = 0;
    check_field();
    check_output("timeout_hour_kept", int'(user_hour_o), last_hour);
    check_output("timeout_min_kept", int'(user_min_o), last_min);

    $display("[TB] random sessions");
    for (int s = 0; s < 6; s++) begin
      if ($urandom_range(0, 1) == 1) apply_stimulus(0, 1);
      run_session($urandom_range(0, 23), $urandom_range(0, 59),
                  $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("[TB] reset during minute edit");
    cur_hour_i = 5'd9;
    cur_min_i  = 6'd9;
    apply_stimulus(1, 0);
    apply_stimulus(0, 1);
    apply_stimulus(1, 0);
    rst_i = 1'b0;
    #1;
    check_output("rst_mid_val", int'(user_time_val_o), 0);
    check_output("rst_mid_hour", int'(user_hour_o), 0);
    check_output("rst_mid_min", int'(user_min_o), 0);
    check_output("rst_mid_edit", int'(edit_o), 0);
    check_output("rst_mid_field", int'(field_o), 0);
    phase     = 0;
    last_hour = 0;
    last_min  = 0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check_field();
    check_output("post_rst_hour", int'(user_hour_o), 0);
    run_session(21, 58, 2, 3);

    repeat (10) @(negedge clk_i);
    check_output("pending_commits", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
